// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int N_BITS = 32,
    parameter int N_OP   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [N_OP-1:0]   op_i,
    input  logic [N_BITS-1:0] a_i,
    input  logic [N_BITS-1:0] b_i,
    input  logic              flush_i,
    output logic [N_BITS-1:0] hi_o,
    output logic [N_BITS-1:0] lo_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              div_zero_o
);

    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [N_OP-1:0] OP_MULT  = N_OP'(0);
    localparam logic [N_OP-1:0] OP_MULTU = N_OP'(1);
    localparam logic [N_OP-1:0] OP_DIV   = N_OP'(2);
    localparam logic [N_OP-1:0] OP_DIVU  = N_OP'(3);
    localparam logic [N_OP-1:0] OP_MTHI  = N_OP'(4);
    localparam logic [N_OP-1:0] OP_MTLO  = N_OP'(5);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [N_BITS-1:0] cneg_w(input logic [N_BITS-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*N_BITS-1:0] cneg_d(input logic [2*N_BITS-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                mt_pend;

    logic [2*N_BITS-1:0] acc;
    logic [N_BITS-1:0]   opb;
    logic                is_div;
    logic                neg_lo;
    logic                neg_hi;
    logic                dz_r;

    logic                is_md;
    logic                is_sgn;
    logic                is_dv;
    logic                is_mt;
    logic                sa;
    logic                sb;
    logic                accept_md;
    logic                accept_mt;
    logic [N_BITS-1:0]   mag_a;
    logic [N_BITS-1:0]   mag_b;

    logic [N_BITS:0]     mul_sum;
    logic [N_BITS:0]     div_diff;
    logic [2*N_BITS-1:0] acc_step;
    logic [2*N_BITS-1:0] prod_fix;
    logic [N_BITS-1:0]   fix_hi;
    logic [N_BITS-1:0]   fix_lo;

    always_comb begin
        is_md     = (op_i == OP_MULT) || (op_i == OP_MULTU) || (op_i == OP_DIV) || (op_i == OP_DIVU);
        is_sgn    = (op_i == OP_MULT) || (op_i == OP_DIV);
        is_dv     = (op_i == OP_DIV)  || (op_i == OP_DIVU);
        is_mt     = (op_i == OP_MTHI) || (op_i == OP_MTLO);
        sa        = is_sgn & a_i[N_BITS-1];
        sb        = is_sgn & b_i[N_BITS-1];
        mag_a     = cneg_w(a_i, sa);
        mag_b     = cneg_w(b_i, sb);
        accept_md = (state == IDLE) && start_i && !flush_i && is_md;
        accept_mt = (state == IDLE) && start_i && !flush_i && is_mt;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*N_BITS-1:0] fast_prod;
    assign fast_prod = {{N_BITS{1'b0}}, mag_a} * {{N_BITS{1'b0}}, mag_b};
`endif

    // One radix-2 step: multiply adds the multiplicand into the upper half and shifts right;
    // divide shifts {rem, quo} left and subtracts the divisor when it fits (borrow in div_diff MSB).
    always_comb begin
        mul_sum  = {1'b0, acc[2*N_BITS-1:N_BITS]} + (acc[0] ? {1'b0, opb} : '0);
        div_diff = acc[2*N_BITS-1:N_BITS-1] - {1'b0, opb};
        if (is_div) begin
            if (div_diff[N_BITS])
                acc_step = {acc[2*N_BITS-2:0], 1'b0};
            else
                acc_step = {div_diff[N_BITS-1:0], acc[N_BITS-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[N_BITS-1:1]};
        end

        prod_fix = cneg_d(acc, neg_lo);
        if (is_div) begin
            fix_lo = dz_r ? '1 : cneg_w(acc[N_BITS-1:0], neg_lo);
            fix_hi = cneg_w(acc[2*N_BITS-1:N_BITS], neg_hi);
        end else begin
            fix_lo = prod_fix[N_BITS-1:0];
            fix_hi = prod_fix[2*N_BITS-1:N_BITS];
        end
    end

    // Datapath: operand magnitudes and result signs captured at start, stepped in CALC.
    always_ff @(posedge clk) begin
        if (accept_md) begin
            is_div <= is_dv;
            dz_r   <= is_dv && (b_i == '0);
            neg_lo <= sa ^ sb;
            neg_hi <= is_dv ? sa : (sa ^ sb);
            opb    <= is_dv ? mag_b : mag_a;
`ifdef MULDIV_FAST_MUL_EN
            acc    <= is_dv ? {{N_BITS{1'b0}}, mag_a} : fast_prod;
`else
            acc    <= {{N_BITS{1'b0}}, (is_dv ? mag_a : mag_b)};
`endif
        end else if (state == CALC) begin
            acc <= acc_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mt_pend    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
        end else begin
            done_o     <= mt_pend;
            div_zero_o <= 1'b0;
            mt_pend    <= accept_mt;
            case (state)
                IDLE: begin
                    if (accept_md) begin
                        busy_o <= 1'b1;
                        cnt    <= CW'(N_BITS - 1);
`ifdef MULDIV_FAST_MUL_EN
                        state  <= is_dv ? CALC : FIX;
`else
                        state  <= CALC;
`endif
                    end else if (accept_mt) begin
                        if (op_i == OP_MTHI)
                            hi_o <= a_i;
                        else
                            lo_o <= a_i;
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (cnt == '0)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (!flush_i) begin
                        hi_o       <= fix_hi;
                        lo_o       <= fix_lo;
                        done_o     <= 1'b1;
                        div_zero_o <= dz_r;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected HI/LO/flag/latency per operation.
module tb_muldiv_unit;

    localparam int N = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = N + 1;
`endif
    localparam int DIV_LAT = N + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [2:0]   op_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         flush_i;
    logic [N-1:0] hi_o;
    logic [N-1:0] lo_o;
    logic         busy_o;
    logic         done_o;
    logic         div_zero_o;

    muldiv_unit #(.N_BITS(N), .N_OP(3)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o),
        .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [N-1:0] sh_hi   = '0;
    logic [N-1:0] sh_lo   = '0;

    function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        logic signed [2*N-1:0] sa, sbv, sq, sr;
        logic [2*N-1:0] pu;
        sa    = $signed({{N{a[N-1]}}, a});
        sbv   = $signed({{N{b[N-1]}}, b});
        e.dz  = 1'b0;
        e.lat = DIV_LAT;
        e.hi  = '0;
        e.lo  = '0;
        case (op)
            3'd0: begin
                sq = sa * sbv;
                e.hi = sq[2*N-1:N]; e.lo = sq[N-1:0]; e.lat = MUL_LAT;
            end
            3'd1: begin
                pu = {{N{1'b0}}, a} * {{N{1'b0}}, b};
                e.hi = pu[2*N-1:N]; e.lo = pu[N-1:0]; e.lat = MUL_LAT;
            end
            default: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (op == 3'd2) begin
                    sq = sa / sbv; sr = sa % sbv;
                    e.lo = sq[N-1:0]; e.hi = sr[N-1:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Starts one operation and waits (bounded) for done_o; k counts edges after the accepting edge.
    task automatic issue_wait(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                              output logic [N-1:0] ohi, output logic [N-1:0] olo, output logic odz,
                              output int lat, output int bcnt, output bit seen);
        int k;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start_i = 1'b0;
        k = 0; bcnt = 0; seen = 1'b0; ohi = '0; olo = '0; odz = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            if (busy_o) bcnt++;
            if (done_o) begin
                seen = 1'b1; ohi = hi_o; olo = lo_o; odz = div_zero_o;
            end else begin
                @(posedge clk);
                k++;
            end
        end
        lat = k;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({hi_o, lo_o, busy_o, done_o, div_zero_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, required all zero",
                     hi_o, lo_o, busy_o, done_o, div_zero_o);
        end
    endtask

    task automatic test_mul();
        logic [2:0] ops[6];
        logic [N-1:0] as[6], bs[6];
        exp_t e, tab[6];
        logic [N-1:0] h, l; logic z; int lat, bc; bit seen;
        ops[0] = 3'd1; as[0] = 32'hFFFFFFFF; bs[0] = 32'hFFFFFFFF;
        tab[0].hi = 32'hFFFFFFFE; tab[0].lo = 32'h00000001; tab[0].dz = 1'b0; tab[0].lat = MUL_LAT;
        ops[1] = 3'd0; as[1] = 32'hFFFFFFF9; bs[1] = 32'd6;
        tab[1].hi = 32'hFFFFFFFF; tab[1].lo = 32'hFFFFFFD6; tab[1].dz = 1'b0; tab[1].lat = MUL_LAT;
        for (int i = 2; i < 6; i++) begin
            ops[i] = 3'($urandom_range(0, 1)); as[i] = $urandom; bs[i] = $urandom;
            tab[i] = model(ops[i], as[i], bs[i]);
        end
        for (int i = 0; i < 6; i++) begin
            sb.push_back(tab[i]);
            issue_wait(ops[i], as[i], bs[i], h, l, z, lat, bc, seen);
            e = sb.pop_front();
            sh_hi = e.hi; sh_lo = e.lo;
            n_tests++;
            if (!seen) begin
                n_fail++; $display("FAIL mul_timeout[%0d]: no done_o within %0d cycles, required %0d", i, lat, e.lat);
            end else if (h !== e.hi || l !== e.lo || z !== e.dz) begin
                n_fail++; $display("FAIL mul_result[%0d]: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b", i, h, l, z, e.hi, e.lo, e.dz);
            end
            n_tests++;
            if (lat != e.lat || bc != e.lat) begin
                n_fail++; $display("FAIL mul_timing[%0d]: latency=%0d busy_cycles=%0d, required %0d", i, lat, bc, e.lat);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0] ops[8];
        logic [N-1:0] as[8], bs[8];
        exp_t e, tab[8];
        logic [N-1:0] h, l; logic z; int lat, bc; bit seen;
        ops[0] = 3'd2; as[0] = 32'hFFFFFFF9; bs[0] = 32'd2;
        tab[0].hi = 32'hFFFFFFFF; tab[0].lo = 32'hFFFFFFFD; tab[0].dz = 1'b0; tab[0].lat = DIV_LAT;
        ops[1] = 3'd3; as[1] = 32'd100; bs[1] = 32'd0;
        tab[1].hi = 32'd100; tab[1].lo = 32'hFFFFFFFF; tab[1].dz = 1'b1; tab[1].lat = DIV_LAT;
        ops[2] = 3'd2; as[2] = 32'h80000000; bs[2] = 32'hFFFFFFFF;
        tab[2].hi = 32'h0; tab[2].lo = 32'h80000000; tab[2].dz = 1'b0; tab[2].lat = DIV_LAT;
        ops[3] = 3'd2; as[3] = 32'hFFFFFFF7; bs[3] = 32'd0;
        tab[3].hi = 32'hFFFFFFF7; tab[3].lo = 32'hFFFFFFFF; tab[3].dz = 1'b1; tab[3].lat = DIV_LAT;
        for (int i = 4; i < 8; i++) begin
            ops[i] = 3'($urandom_range(2, 3)); as[i] = $urandom;
            bs[i] = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            if (i == 5) bs[i] = -bs[i];
            tab[i] = model(ops[i], as[i], bs[i]);
        end
        for (int i = 0; i < 8; i++) begin
            sb.push_back(tab[i]);
            issue_wait(ops[i], as[i], bs[i], h, l, z, lat, bc, seen);
            e = sb.pop_front();
            sh_hi = e.hi; sh_lo = e.lo;
            n_tests++;
            if (!seen) begin
                n_fail++; $display("FAIL div_timeout[%0d]: no done_o within %0d cycles, required %0d", i, lat, e.lat);
            end else if (h !== e.hi || l !== e.lo || z !== e.dz) begin
                n_fail++; $display("FAIL div_result[%0d]: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b", i, h, l, z, e.hi, e.lo, e.dz);
            end
            n_tests++;
            if (lat != e.lat || bc != e.lat) begin
                n_fail++; $display("FAIL div_timing[%0d]: latency=%0d busy_cycles=%0d, required %0d", i, lat, bc, e.lat);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        exp_t e;
        e.hi = 32'h12345678; e.lo = sh_lo; e.dz = 1'b0; e.lat = 1; sb.push_back(e);
        e.hi = 32'h12345678; e.lo = 32'h9ABCDEF0; sb.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 3'd4; a_i = 32'h12345678; b_i = '0;
        @(posedge clk); #1;
        op_i = 3'd5; a_i = 32'h9ABCDEF0;
        n_tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || hi_o !== 32'h12345678) begin
            n_fail++; $display("FAIL mthi_write: hi=%h done=%b busy=%b, required hi=12345678 done=0 busy=0", hi_o, done_o, busy_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || hi_o !== e.hi || div_zero_o !== 1'b0) begin
            n_fail++; $display("FAIL mthi_done: hi=%h done=%b busy=%b dz=%b, required hi=%h done=1 busy=0 dz=0", hi_o, done_o, busy_o, div_zero_o, e.hi);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_tests++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || lo_o !== e.lo || hi_o !== e.hi) begin
            n_fail++; $display("FAIL mtlo_done: hi=%h lo=%h done=%b busy=%b, required hi=%h lo=%h done=1 busy=0", hi_o, lo_o, done_o, busy_o, e.hi, e.lo);
        end
        sh_hi = e.hi; sh_lo = e.lo;
        @(posedge clk); #1;
        n_tests++;
        if (done_o !== 1'b0) begin
            n_fail++; $display("FAIL mt_done_pulse: done=%b, required 0", done_o);
        end
    endtask

    task automatic test_unused_op();
        bit bad = 1'b0;
        for (int c = 6; c < 8; c++) begin
            @(posedge clk); #1;
            start_i = 1'b1; op_i = 3'(c); a_i = 32'hDEADBEEF; b_i = 32'd3;
            @(posedge clk); #1;
            start_i = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (done_o || busy_o) bad = 1'b1;
            end
        end
        n_tests++;
        if (bad || hi_o !== sh_hi || lo_o !== sh_lo) begin
            n_fail++; $display("FAIL unused_op: hi=%h lo=%h activity=%b, required hi=%h lo=%h activity=0", hi_o, lo_o, bad, sh_hi, sh_lo);
        end
    endtask

    task automatic test_flush();
        bit bad = 1'b0;
        exp_t e;
        logic [N-1:0] h, l; logic z; int lat, bc; bit seen;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 3'd3; a_i = 32'd50; b_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start_i = (c == 4);
            if (c == 4) begin op_i = 3'd1; a_i = 32'd3; b_i = 32'd3; end
            flush_i = (c == 9);
            if (done_o) bad = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy: busy=%b after flush edge, required 0", busy_o);
        end
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done_o || busy_o) bad = 1'b1;
        end
        n_tests++;
        if (bad || hi_o !== sh_hi || lo_o !== sh_lo) begin
            n_fail++; $display("FAIL flush_abort: hi=%h lo=%h activity=%b, required hi=%h lo=%h activity=0", hi_o, lo_o, bad, sh_hi, sh_lo);
        end
        e.hi = 32'd1; e.lo = 32'd7; e.dz = 1'b0; e.lat = DIV_LAT;
        sb.push_back(e);
        issue_wait(3'd3, 32'd50, 32'd7, h, l, z, lat, bc, seen);
        e = sb.pop_front();
        sh_hi = e.hi; sh_lo = e.lo;
        n_tests++;
        if (!seen || h !== e.hi || l !== e.lo || lat != e.lat) begin
            n_fail++; $display("FAIL flush_rerun: seen=%b hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=%0d", seen, h, l, lat, e.hi, e.lo, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit seen = 1'b0;
        int k = 0;
        int bc = 0;
        e.hi = 32'd1; e.lo = 32'd333; e.dz = 1'b0; e.lat = DIV_LAT;
        sb.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 3'd3; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
            else begin @(posedge clk); k++; end
        end
        e = sb.pop_front();
        n_tests++;
        if (!seen || hi_o !== e.hi || lo_o !== e.lo) begin
            n_fail++; $display("FAIL b2b_first: seen=%b hi=%h lo=%h, required hi=%h lo=%h", seen, hi_o, lo_o, e.hi, e.lo);
        end
        // Start in the cycle done_o is high.
        start_i = 1'b1; op_i = 3'd0; a_i = -32'd123; b_i = 32'd456;
        sb.push_back(model(3'd0, -32'd123, 32'd456));
        @(posedge clk); #1;
        start_i = 1'b0;
        seen = 1'b0; k = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            if (busy_o) bc++;
            if (done_o) seen = 1'b1;
            else begin @(posedge clk); k++; end
        end
        e = sb.pop_front();
        sh_hi = e.hi; sh_lo = e.lo;
        n_tests++;
        if (!seen || hi_o !== e.hi || lo_o !== e.lo || k != e.lat || bc != e.lat) begin
            n_fail++; $display("FAIL b2b_second: seen=%b hi=%h lo=%h lat=%0d busy=%0d, required hi=%h lo=%h lat=%0d", seen, hi_o, lo_o, k, bc, e.hi, e.lo, e.lat);
        end
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        exp_t e;
        logic [N-1:0] h, l; logic z; int lat, bc; bit seen;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 3'd0; a_i = 32'h00012345; b_i = 32'hFFFF0001;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (14) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if ({hi_o, lo_o, busy_o, done_o, div_zero_o} !== '0) begin
            n_fail++; $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, required all zero", hi_o, lo_o, busy_o, done_o);
        end
        sh_hi = '0; sh_lo = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o || busy_o) bad = 1'b1;
        end
        n_tests++;
        if (bad || hi_o !== '0 || lo_o !== '0) begin
            n_fail++; $display("FAIL reset_quiet: hi=%h lo=%h activity=%b, required zero and idle", hi_o, lo_o, bad);
        end
        e.hi = '0; e.lo = 32'd15; e.dz = 1'b0; e.lat = MUL_LAT;
        sb.push_back(e);
        issue_wait(3'd1, 32'd3, 32'd5, h, l, z, lat, bc, seen);
        e = sb.pop_front();
        n_tests++;
        if (!seen || h !== e.hi || l !== e.lo || lat != e.lat || bc != e.lat) begin
            n_fail++; $display("FAIL post_reset_mul: seen=%b hi=%h lo=%h lat=%0d busy=%0d, required hi=%h lo=%h lat=%0d", seen, h, l, lat, bc, e.hi, e.lo, e.lat);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_mul();
        test_div();
        test_mthi_mtlo();
        test_unused_op();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
